// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode encoding and counter-width helper for led_driver
// Purpose: mode constants used by the driver and its bench, plus a width
//          helper that keeps single-value counters at least one bit wide.
// Ports:   none (package)
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_PWM    = 2'd2,
    MODE_CHASE  = 2'd3
  } led_mode_e;

  // Width of a counter spanning 0..range-1; a range of 1 still needs a bit.
  function automatic int cnt_w(input int range);
    return (range <= 1) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler producing a one-cycle step tick
// Purpose: counts clk cycles 0..TICK_DIV-1 and flags the last count.
// Ports:   clk  - system clock
//          rstn - asynchronous active-low reset
//          clr  - synchronous restart of the prescaler from 0
//          tick - one-cycle strobe while the count sits at TICK_DIV-1
module led_tick_gen
  import led_pkg::*;
#(
  parameter int TICK_DIV = 12000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int            W    = cnt_w(TICK_DIV);
  localparam logic [W-1:0]  LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/led_driver.sv
// rtl/led_driver.sv - N-channel LED driver: static, blink, PWM and chaser modes
// Purpose: registered LED outputs whose behaviour is chosen at run time.
// Ports:   clk     - system clock
//          rstn    - asynchronous active-low reset
//          mode    - 0 static, 1 blink, 2 pwm, 3 chase
//          pattern - LED enable mask applied in every mode
//          duty    - PWM on-count per 2^PWM_BITS cycles
//          led     - registered active-high LED drive
module led_driver
  import led_pkg::*;
#(
  parameter int N_LEDS      = 4,
  parameter int TICK_DIV    = 12000,
  parameter int BLINK_TICKS = 250,
  parameter int CHASE_TICKS = 100,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          mode,
  input  logic [N_LEDS-1:0]   pattern,
  input  logic [PWM_BITS-1:0] duty,
  output logic [N_LEDS-1:0]   led
);

  localparam int               BW         = cnt_w(BLINK_TICKS);
  localparam int               CW         = cnt_w(CHASE_TICKS);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [CW-1:0]    CHASE_LAST = CW'(CHASE_TICKS - 1);
  localparam logic [N_LEDS-1:0] CHASE_INIT = N_LEDS'(1);

  led_mode_e           r_mode_q;
  logic [BW-1:0]       r_blink_cnt;
  logic                r_phase;
  logic [CW-1:0]       r_chase_cnt;
  logic [N_LEDS-1:0]   r_chase;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [N_LEDS-1:0]   r_led;

  logic                w_mode_chg;
  logic                w_tick;
  logic [N_LEDS-1:0]   w_chase_rot;
  logic [N_LEDS-1:0]   w_led_next;

  assign w_mode_chg = (mode != r_mode_q);

  // Rotate-left written with shifts so N_LEDS=1 degenerates to a no-op.
  assign w_chase_rot = (r_chase << 1) | (r_chase >> (N_LEDS - 1));

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .clr  (w_mode_chg),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode_q <= MODE_STATIC;
      r_led    <= '0;
    end else begin
      r_mode_q <= led_mode_e'(mode);
      r_led    <= w_led_next;
    end
  end

  // Mode change takes priority over a coincident tick: everything restarts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_chase_cnt <= '0;
      r_chase     <= CHASE_INIT;
      r_pwm_cnt   <= '0;
    end else if (w_mode_chg) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_chase_cnt <= '0;
      r_chase     <= CHASE_INIT;
      r_pwm_cnt   <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_tick) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
        if (r_chase_cnt == CHASE_LAST) begin
          r_chase_cnt <= '0;
          r_chase     <= w_chase_rot;
        end else begin
          r_chase_cnt <= r_chase_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_led_next = '0;
    case (r_mode_q)
      MODE_STATIC: w_led_next = pattern;
      MODE_BLINK:  w_led_next = r_phase ? pattern : '0;
      MODE_PWM:    w_led_next = (r_pwm_cnt < duty) ? pattern : '0;
      MODE_CHASE:  w_led_next = r_chase & pattern;
      default:     w_led_next = '0;
    endcase
  end

  assign led = r_led;

endmodule

// File: tb/tb_led_driver.sv
// tb/tb_led_driver.sv - directed self-checking bench for led_driver
module tb_led_driver;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int BT = 2;
  localparam int CT = 1;
  localparam int PB = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    mode;
  logic [N-1:0]  pattern;
  logic [PB-1:0] duty;
  logic [N-1:0]  led;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_driver #(
    .N_LEDS      (N),
    .TICK_DIV    (TD),
    .BLINK_TICKS (BT),
    .CHASE_TICKS (CT),
    .PWM_BITS    (PB)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .mode    (mode),
    .pattern (pattern),
    .duty    (duty),
    .led     (led)
  );

  typedef struct {
    logic [1:0]    mode;
    logic [N-1:0]  pattern;
    logic [PB-1:0] duty;
    logic [N-1:0]  exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: led=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    logic [N-1:0] e;

    rstn    = 1'b0;
    mode    = 2'd0;
    pattern = '0;
    duty    = '0;

    vecs[0] = '{2'd0, 4'b1011, 3'd0, 4'b1011};
    vecs[1] = '{2'd0, 4'b0100, 3'd5, 4'b0100};
    vecs[2] = '{2'd0, 4'b0000, 3'd7, 4'b0000};
    vecs[3] = '{2'd0, 4'b1111, 3'd1, 4'b1111};
    vecs[4] = '{2'd0, 4'b1001, 3'd0, 4'b1001};

    repeat (2) @(negedge clk);
    check("reset", led, 4'b0000);
    rstn = 1'b1;

    // Static table: one-cycle latency from pattern to led.
    for (int i = 0; i < 5; i++) begin
      mode    = vecs[i].mode;
      pattern = vecs[i].pattern;
      duty    = vecs[i].duty;
      @(negedge clk);
      check($sformatf("static vec%0d", i), led, vecs[i].exp);
    end

    // Blink: first edge still shows static, then 8 dark / 8 lit.
    mode    = 2'd1;
    pattern = 4'b1111;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) e = 4'b1111;
      else        e = (((k - 2) / 8) % 2 == 1) ? 4'b1111 : 4'b0000;
      check($sformatf("blink k=%0d", k), led, e);
    end

    // PWM duty=3, then 0, then 7.
    mode    = 2'd2;
    pattern = 4'b0011;
    duty    = 3'd3;
    @(negedge clk);
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      e = (((k - 2) % 8) < 3) ? 4'b0011 : 4'b0000;
      check($sformatf("pwm d3 k=%0d", k), led, e);
    end
    duty = 3'd0;
    for (int k = 18; k <= 25; k++) begin
      @(negedge clk);
      check($sformatf("pwm d0 k=%0d", k), led, 4'b0000);
    end
    duty = 3'd7;
    for (int k = 26; k <= 33; k++) begin
      @(negedge clk);
      e = (((k - 2) % 8) == 7) ? 4'b0000 : 4'b0011;
      check($sformatf("pwm d7 k=%0d", k), led, e);
    end

    // Chase: advance every 4 cycles with wrap, then a masked position.
    mode    = 2'd3;
    pattern = 4'b1111;
    @(negedge clk);
    for (int k = 2; k <= 21; k++) begin
      @(negedge clk);
      e = 4'b0001 << (((k - 2) / 4) % 4);
      check($sformatf("chase k=%0d", k), led, e);
    end
    pattern = 4'b1101;
    for (int k = 22; k <= 26; k++) begin
      @(negedge clk);
      e = (4'b0001 << (((k - 2) / 4) % 4)) & 4'b1101;
      check($sformatf("chase mask k=%0d", k), led, e);
    end

    // Mode change mid-chase to blink and back.
    mode = 2'd1;
    @(negedge clk);
    check("mc chase last", led, 4'b0100);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("mc blink dark k=%0d", k), led, 4'b0000);
    end
    mode = 2'd3;
    @(negedge clk);
    check("mc blink last", led, 4'b0000);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("mc chase restart k=%0d", k), led, 4'b0001);
    end
    @(negedge clk);
    check("mc chase step1 masked", led, 4'b0000);

    // Asynchronous reset while blink is lit.
    mode    = 2'd1;
    pattern = 4'b1010;
    @(negedge clk);
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      e = (k >= 10) ? 4'b1010 : 4'b0000;
      check($sformatf("pre-reset blink k=%0d", k), led, e);
    end
    #2 rstn = 1'b0;
    #1 check("async reset", led, 4'b0000);
    repeat (2) begin
      @(negedge clk);
      check("held in reset", led, 4'b0000);
    end
    mode = 2'd0;
    rstn = 1'b1;
    #1 check("released no edge", led, 4'b0000);
    @(negedge clk);
    check("first edge after release", led, 4'b1010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
